spi_slave_responder: RTL

//  SPI responder (slave) end of the master/slave link. It connects to the master's sclk/ss_n/mosi pins and drives miso.
//  All logic runs on the local system clock; the SPI pins are oversampled through synchronizers.

---
 rtl/spi_slave_responder_pkg.sv | 14 +
 rtl/spi_slave_responder_if.sv | 36 +++
 rtl/spi_slave_responder_sync.sv | 30 +++
 rtl/spi_slave_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared types and constants for the SPI slave responder.
//   state_t        : frame FSM states (IDLE, LOAD, SHIFT)
//   DEFAULT_DATA_W : default SPI word width
package spi_slave_responder_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

endpackage

// File: rtl/spi_slave_responder_if.sv
// Bundle of SPI pins plus the parallel tx/rx side of the responder.
//   slave modport  : responder view (SPI pins and tx handshake in, miso/status out)
//   master modport : the opposite view, used by whatever drives the pins and tx side
//   sclk, ss_n, mosi, miso, miso_oe       : SPI link
//   tx_data, tx_valid, tx_ready           : tx holding register handshake
//   rx_data, rx_valid                     : received word and its one-cycle strobe
//   busy, tx_underrun, frame_abort        : status and event strobes
interface spi_slave_responder_if
   import spi_slave_responder_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
);
   logic              sclk;
   logic              ss_n;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              tx_underrun;
   logic              frame_abort;

   modport slave (
      input  sclk, ss_n, mosi, tx_data, tx_valid,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
   );

   modport master (
      output sclk, ss_n, mosi, tx_data, tx_valid,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
   );
endinterface

// File: rtl/spi_slave_responder_sync.sv
// Multi-stage flip-flop synchronizer for an asynchronous single-bit input.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (last stage); all stages reset to RST_VAL
module spi_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder, oversampling the SPI pins on the local clock.
//   clk, rst : system clock (sclk must be <= clk/8), asynchronous active-high reset
//   bus      : slave modport carrying SPI pins, tx holding-register handshake,
//              received word with strobe, and busy/underrun/abort status
module spi_slave_responder
   import spi_slave_responder_pkg::*;
#(
   parameter int unsigned DATA_W      = DEFAULT_DATA_W,
   parameter logic        CPOL        = 1'b0,
   parameter logic        CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_slave_responder_if.slave bus
);
   localparam int unsigned     CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_s, ss_s, mosi_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d(bus.ss_n), .q(ss_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_s));

   state_t              state_q, state_d;
   logic                sclk_prev_q, sclk_prev_d;
   logic                ss_prev_q, ss_prev_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                hold_valid_q, hold_valid_d;
   logic                fresh_q, fresh_d;
   logic                pend_underrun_q, pend_underrun_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                miso_q, miso_d;
   logic                tx_underrun_q, tx_underrun_d;
   logic                frame_abort_q, frame_abort_d;

   logic                lead, trail, sample_edge, shift_edge, ss_fall, ss_rise;
   logic                consume, reload;
   logic [DATA_W-1:0]   load_word, tx_word;

   always_comb begin
      state_d         = state_q;
      sclk_prev_d     = sclk_s;
      ss_prev_d       = ss_s;
      bit_cnt_d       = bit_cnt_q;
      tx_shift_d      = tx_shift_q;
      rx_shift_d      = rx_shift_q;
      hold_d          = hold_q;
      hold_valid_d    = hold_valid_q;
      fresh_d         = fresh_q;
      pend_underrun_d = pend_underrun_q;
      done_d          = 1'b0;
      rx_data_d       = rx_data_q;
      rx_valid_d      = 1'b0;
      miso_d          = miso_q;
      tx_underrun_d   = 1'b0;
      frame_abort_d   = 1'b0;
      consume         = 1'b0;
      reload          = 1'b0;
      tx_word         = tx_shift_q;
      load_word       = hold_valid_q ? hold_q : '0;

      lead        = (sclk_s != sclk_prev_q) && (sclk_s != CPOL);
      trail       = (sclk_s != sclk_prev_q) && (sclk_s == CPOL);
      sample_edge = CPHA ? trail : lead;
      shift_edge  = CPHA ? lead : trail;
      ss_fall     = !ss_s && ss_prev_q;
      ss_rise     = ss_s && !ss_prev_q;

      // Completed word is published one cycle after its final sample.
      if (done_q) begin
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
      end

      if (ss_rise) begin
         state_d         = IDLE;
         frame_abort_d   = (bit_cnt_q != '0);
         bit_cnt_d       = '0;
         miso_d          = 1'b0;
         fresh_d         = 1'b0;
         pend_underrun_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               miso_d = 1'b0;
               if (ss_fall) state_d = LOAD;
            end
            LOAD: begin
               consume         = hold_valid_q;
               tx_underrun_d   = !hold_valid_q;
               bit_cnt_d       = '0;
               fresh_d         = 1'b1;
               pend_underrun_d = 1'b0;
               if (!CPHA) begin
                  miso_d     = load_word[DATA_W-1];
                  tx_shift_d = load_word << 1;
               end else begin
                  miso_d     = 1'b0;
                  tx_shift_d = load_word;
               end
               state_d = SHIFT;
            end
            SHIFT: begin
               if (sample_edge) begin
                  rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d = '0;
                     done_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
                  // A CPHA=0 reload that found the holding register empty is
                  // only reported once the master really starts clocking that
                  // word, so the idle trailing edge at frame end is silent.
                  if (pend_underrun_q) begin
                     tx_underrun_d   = 1'b1;
                     pend_underrun_d = 1'b0;
                  end
               end
               if (shift_edge) begin
                  if (CPHA) begin
                     reload  = (bit_cnt_q == '0) && !fresh_q;
                     fresh_d = 1'b0;
                  end else begin
                     reload = (bit_cnt_q == '0);
                  end
                  if (reload) begin
                     if (hold_valid_q) begin
                        tx_word = hold_q;
                        consume = 1'b1;
                     end else begin
                        tx_word = '0;
                        if (CPHA) tx_underrun_d   = 1'b1;
                        else      pend_underrun_d = 1'b1;
                     end
                  end
                  miso_d     = tx_word[DATA_W-1];
                  tx_shift_d = tx_word << 1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Load and write are mutually exclusive: a write needs an empty register,
      // a load from it needs a full one. A write during an empty load is kept.
      if (consume) hold_valid_d = 1'b0;
      if (bus.tx_valid && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_d       = bus.tx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         sclk_prev_q     <= CPOL;
         ss_prev_q       <= 1'b1;
         bit_cnt_q       <= '0;
         tx_shift_q      <= '0;
         rx_shift_q      <= '0;
         hold_q          <= '0;
         hold_valid_q    <= 1'b0;
         fresh_q         <= 1'b0;
         pend_underrun_q <= 1'b0;
         done_q          <= 1'b0;
         rx_data_q       <= '0;
         rx_valid_q      <= 1'b0;
         miso_q          <= 1'b0;
         tx_underrun_q   <= 1'b0;
         frame_abort_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         sclk_prev_q     <= sclk_prev_d;
         ss_prev_q       <= ss_prev_d;
         bit_cnt_q       <= bit_cnt_d;
         tx_shift_q      <= tx_shift_d;
         rx_shift_q      <= rx_shift_d;
         hold_q          <= hold_d;
         hold_valid_q    <= hold_valid_d;
         fresh_q         <= fresh_d;
         pend_underrun_q <= pend_underrun_d;
         done_q          <= done_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         miso_q          <= miso_d;
         tx_underrun_q   <= tx_underrun_d;
         frame_abort_q   <= frame_abort_d;
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = (state_q != IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.tx_ready    = !hold_valid_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = tx_underrun_q;
   assign bus.frame_abort = frame_abort_q;
endmodule
